// File: rtl/score_keeper.sv
// score_keeper: two-player BCD scoring stage with post-point lockout,
// same-cycle press cancellation and a frozen win state.
// Every output comes straight from a register; the combinational block
// only computes the values those registers load at the next edge.
module score_keeper #(
    parameter int WIN_SCORE = 7,   // target score, 1..99
    parameter int LOCKOUT   = 3    // ignore window after a point, 0..255
) (
    input  logic       clk,
    input  logic       reset,      // synchronous, active-low
    input  logic       clear,      // synchronous game restart, active-high
    input  logic       p1_press,
    input  logic       p2_press,
    output logic [3:0] p1_tens,
    output logic [3:0] p1_ones,
    output logic [3:0] p2_tens,
    output logic [3:0] p2_ones,
    output logic [1:0] winner,
    output logic       game_over,
    output logic       point
);

    // The state encoding matches the winner code, so 2'b11 is never used.
    typedef enum logic [1:0] {
        ST_PLAY   = 2'b00,
        ST_P1_WIN = 2'b01,
        ST_P2_WIN = 2'b10
    } state_t;

    // Target score split into BCD digits once, at elaboration.
    localparam logic [3:0] WIN_TENS  = 4'(WIN_SCORE / 10);
    localparam logic [3:0] WIN_ONES  = 4'(WIN_SCORE % 10);
    localparam logic [7:0] WIN_BCD   = {WIN_TENS, WIN_ONES};
    localparam logic [7:0] LOCK_LOAD = 8'(LOCKOUT);

    // Adds one to a two-digit BCD score {tens, ones}.
    // The score stops at WIN_SCORE <= 99, so the tens digit cannot wrap.
    function automatic logic [7:0] bcd_inc(input logic [7:0] score);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = score[7:4];
        ones = score[3:0];
        if (ones == 4'd9) begin
            ones = 4'd0;
            tens = tens + 4'd1;
        end else begin
            ones = ones + 4'd1;
        end
        return {tens, ones};
    endfunction

    // True when a BCD score has reached the target.
    function automatic logic is_win(input logic [7:0] score);
        return (score == WIN_BCD);
    endfunction

    // Maps a game state onto the external winner code.
    function automatic logic [1:0] winner_code(input state_t st);
        logic [1:0] code;
        case (st)
            ST_P1_WIN: code = 2'b01;
            ST_P2_WIN: code = 2'b10;
            ST_PLAY:   code = 2'b00;
            default:   code = 2'b00;
        endcase
        return code;
    endfunction

    // Registered state.
    state_t     r_state;
    logic [7:0] r_p1_score;     // {tens, ones}
    logic [7:0] r_p2_score;     // {tens, ones}
    logic [7:0] r_lock;         // cycles of lockout still to run
    logic       r_point;
    logic [1:0] r_winner;
    logic       r_game_over;

    // Next-state values.
    state_t     w_state_nxt;
    logic [7:0] w_p1_nxt;
    logic [7:0] w_p2_nxt;
    logic [7:0] w_lock_nxt;
    logic       w_point_nxt;
    logic [1:0] w_winner_nxt;
    logic       w_game_over_nxt;

    // Incremented scores, shared by the acceptance and win-detect paths.
    logic [7:0] w_p1_inc;
    logic [7:0] w_p2_inc;
    logic       w_only_p1;
    logic       w_only_p2;

    assign w_p1_inc  = bcd_inc(r_p1_score);
    assign w_p2_inc  = bcd_inc(r_p2_score);
    // Simultaneous presses cancel, so only a lone press can score.
    assign w_only_p1 = p1_press & ~p2_press;
    assign w_only_p2 = p2_press & ~p1_press;

    // Next-state, score, lockout and point decode for the game FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_p1_nxt    = r_p1_score;
        w_p2_nxt    = r_p2_score;
        w_lock_nxt  = r_lock;
        w_point_nxt = 1'b0;
        case (r_state)
            ST_PLAY: begin
                if (r_lock != 8'd0) begin
                    // Lockout runs down regardless of what is pressed.
                    w_lock_nxt = r_lock - 8'd1;
                end else if (w_only_p1) begin
                    w_p1_nxt    = w_p1_inc;
                    w_lock_nxt  = LOCK_LOAD;
                    w_point_nxt = 1'b1;
                    if (is_win(w_p1_inc)) begin
                        w_state_nxt = ST_P1_WIN;
                    end else begin
                        w_state_nxt = ST_PLAY;
                    end
                end else if (w_only_p2) begin
                    w_p2_nxt    = w_p2_inc;
                    w_lock_nxt  = LOCK_LOAD;
                    w_point_nxt = 1'b1;
                    if (is_win(w_p2_inc)) begin
                        w_state_nxt = ST_P2_WIN;
                    end else begin
                        w_state_nxt = ST_PLAY;
                    end
                end else begin
                    // No press, or two presses that cancel each other.
                    w_lock_nxt = 8'd0;
                end
            end
            ST_P1_WIN, ST_P2_WIN: begin
                // Frozen until reset or clear; presses are ignored.
                w_state_nxt = r_state;
                w_lock_nxt  = 8'd0;
            end
            default: begin
                // Unreachable encoding: recover into a fresh game.
                w_state_nxt = ST_PLAY;
                w_p1_nxt    = 8'd0;
                w_p2_nxt    = 8'd0;
                w_lock_nxt  = 8'd0;
            end
        endcase
    end

    // Winner flags follow the next state so they rise with the final digit.
    always_comb begin
        w_winner_nxt    = winner_code(w_state_nxt);
        w_game_over_nxt = (w_state_nxt != ST_PLAY);
    end

    // FSM state register with reset and clear returning to PLAY.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_PLAY;
        end else if (clear) begin
            r_state <= ST_PLAY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath registers: scores, lockout counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_p1_score  <= 8'd0;
            r_p2_score  <= 8'd0;
            r_lock      <= 8'd0;
            r_point     <= 1'b0;
            r_winner    <= 2'b00;
            r_game_over <= 1'b0;
        end else if (clear) begin
            // A press arriving with clear is discarded here.
            r_p1_score  <= 8'd0;
            r_p2_score  <= 8'd0;
            r_lock      <= 8'd0;
            r_point     <= 1'b0;
            r_winner    <= 2'b00;
            r_game_over <= 1'b0;
        end else begin
            r_p1_score  <= w_p1_nxt;
            r_p2_score  <= w_p2_nxt;
            r_lock      <= w_lock_nxt;
            r_point     <= w_point_nxt;
            r_winner    <= w_winner_nxt;
            r_game_over <= w_game_over_nxt;
        end
    end

    assign p1_tens   = r_p1_score[7:4];
    assign p1_ones   = r_p1_score[3:0];
    assign p2_tens   = r_p2_score[7:4];
    assign p2_ones   = r_p2_score[3:0];
    assign winner    = r_winner;
    assign game_over = r_game_over;
    assign point     = r_point;

endmodule
